// File: rtl/my_bin2bcd.sv
// ---------------------------------------------------------------------------
// my_bin2bcd
//   Sequential binary-to-BCD converter using shift-add-3 (double dabble).
//   A value is accepted on a valid/ready handshake, converted over IN_W shift
//   cycles, and the BCD result register is loaded in one step when the
//   conversion completes, so a downstream display never sees partial digits.
//   Values above MAXV = 10**DIGITS - 1 saturate to all 9s and raise ovf.
//
// Parameters
//   IN_W    binary input width (1..16)
//   DIGITS  number of BCD digits produced (1..4)
//
// Ports
//   clk        sole clock, all logic on posedge
//   rst        synchronous, active-high reset
//   in_data    unsigned binary input value
//   in_valid   in_data is valid this cycle
//   in_ready   block is idle and will accept in_data (registered)
//   bcd        result digits, digit i at [4i+3:4i], digit 0 = units
//   ovf        last accepted value exceeded MAXV; held with bcd
//   out_valid  one-cycle pulse when bcd/ovf have just been updated
//   lz_mask    bit i set when digit i is a leading zero
//
// Configuration
//   MY_BIN2BCD_LZB_EN  when defined, lz_mask is computed at completion
//                      (units digit never flagged, all zero on overflow).
//                      When undefined, lz_mask is tied to zero.
// ---------------------------------------------------------------------------
module my_bin2bcd #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  out_valid,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (IN_W < 2) ? 1 : $clog2(IN_W);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  localparam logic [31:0] MAXV = (DIGITS == 1) ? 32'd9   :
                                 (DIGITS == 2) ? 32'd99  :
                                 (DIGITS == 3) ? 32'd999 : 32'd9999;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [IN_W-1:0]  shift_q;
  logic [BCD_W-1:0] scratch_q;
  logic             ovf_n;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [IN_W-1:0]  shift_nxt;
  logic [BCD_W-1:0] final_bcd;
  logic             in_big;

  // One double-dabble step: add 3 to every digit that is 5 or more, then
  // shift the combined {scratch, shift} register left by one. Any bit shifted
  // out of the top digit is lost, which can only happen when the value is
  // already known to overflow.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_nxt, shift_nxt} = {adj, shift_q} << 1;
  end

  assign in_big    = {{(32-IN_W){1'b0}}, in_data} > MAXV;
  assign final_bcd = ovf_n ? {DIGITS{4'h9}} : scratch_nxt;

  // The result registers are loaded on the edge that performs the last shift,
  // so the new bcd and the out_valid pulse coincide with the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_n     <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shift_q   <= in_data;
            scratch_q <= '0;
            count     <= '0;
            ovf_n     <= in_big;
            in_ready  <= 1'b0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_q   <= shift_nxt;
          scratch_q <= scratch_nxt;
          count     <= count + 1'b1;
          if (count == LAST_CNT) begin
            bcd       <= final_bcd;
            ovf       <= ovf_n;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MY_BIN2BCD_LZB_EN
  logic [DIGITS-1:0] lz_nxt;
  logic [DIGITS-1:0] lz_q;
  logic              upper_zero;

  // Walk from the most significant digit down: a digit is a leading zero only
  // while every digit above it (and itself) is zero. Units are always shown.
  always_comb begin
    lz_nxt     = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (final_bcd[4*i +: 4] == 4'd0);
      lz_nxt[i]  = upper_zero & ~ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_q <= '0;
    end else if (state == S_SHIFT && count == LAST_CNT) begin
      lz_q <= lz_nxt;
    end
  end

  assign lz_mask = lz_q;
`else
  assign lz_mask = '0;
`endif

endmodule
